// File: rtl/adc_link_master_pkg.sv
// adc_link_master_pkg: shared constants and types for the ADC link master.
//   - command byte marker and frame tags for the two-byte ADC frame
//   - TX / RX FSM state encodings
//   - default parameter values and the command byte builder
package adc_link_master_pkg;

  // Command byte: {CmdMarker, 3'b000, code[2:0]}
  localparam logic [1:0] CmdMarker = 2'b01;

  // Frame tags carried in bits [7:6] of each received byte
  localparam logic [1:0] TagHi = 2'b10;
  localparam logic [1:0] TagLo = 2'b00;

  localparam int unsigned CodeMaxDefault     = 5;
  localparam int unsigned TimeoutClksDefault = 48000;

  typedef enum logic [1:0] {
    TIdle = 2'd0,
    TReq  = 2'd1,
    TBusy = 2'd2
  } tx_state_e;

  typedef enum logic {
    RWaitHi = 1'b0,
    RWaitLo = 1'b1
  } rx_state_e;

  function automatic logic [7:0] cmd_byte(input logic [2:0] code);
    return {CmdMarker, 3'b000, code};
  endfunction

endpackage

// File: rtl/adc_frame_deframer.sv
// adc_frame_deframer: rebuilds 12-bit ADC readings from two-byte UART frames.
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   data_received[7:0] byte from uart_rx
//   rx_done            byte-ready from uart_rx (pulse or level, edge-detected)
//   parity_error       uart_rx parity flag, only looked at on a byte event
//   adc_value[11:0]    last good reading, held between updates
//   adc_valid          one-cycle pulse when adc_value updates
//   frame_error        one-cycle pulse on any framing fault or timeout
module adc_frame_deframer
  import adc_link_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = TimeoutClksDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_received,
  input  logic        rx_done,
  input  logic        parity_error,
  output logic [11:0] adc_value,
  output logic        adc_valid,
  output logic        frame_error
);

  localparam int unsigned TimerW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CLKS - 1);

  rx_state_e         state_q, state_d;
  logic              rx_prev_q;
  logic [5:0]        hi_q, hi_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [11:0]       value_q, value_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;

  logic       byte_evt;
  logic [1:0] tag;

  // One event per byte even when rx_done is held as a level.
  assign byte_evt = rx_done & ~rx_prev_q;
  assign tag      = data_received[7:6];

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    timer_d = timer_q;
    value_d = value_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    if (byte_evt) begin
      // A byte landing on the timeout cycle takes priority over the timeout.
      if (parity_error) begin
        ferr_d  = 1'b1;
        state_d = RWaitHi;
      end else begin
        case (state_q)
          RWaitHi: begin
            if (tag == TagHi) begin
              hi_d    = data_received[5:0];
              timer_d = '0;
              state_d = RWaitLo;
            end else begin
              ferr_d = 1'b1;
            end
          end
          RWaitLo: begin
            if (tag == TagLo) begin
              value_d = {hi_q, data_received[5:0]};
              valid_d = 1'b1;
              state_d = RWaitHi;
            end else if (tag == TagHi) begin
              // Lost low byte: report it, but resync on this new high byte.
              ferr_d  = 1'b1;
              hi_d    = data_received[5:0];
              timer_d = '0;
            end else begin
              ferr_d  = 1'b1;
              state_d = RWaitHi;
            end
          end
          default: state_d = RWaitHi;
        endcase
      end
    end else if (state_q == RWaitLo) begin
      if (timer_q == TimerMax) begin
        ferr_d  = 1'b1;
        state_d = RWaitHi;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RWaitHi;
      rx_prev_q <= 1'b0;
      hi_q      <= '0;
      timer_q   <= '0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_prev_q <= rx_done;
      hi_q      <= hi_d;
      timer_q   <= timer_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign adc_value   = value_q;
  assign adc_valid   = valid_q;
  assign frame_error = ferr_q;

endmodule

// File: rtl/adc_link_master.sv
// adc_link_master: main-board end of the UART link to the gate-driver/ADC board.
// Ports:
//   clk, reset          system clock (48 MHz), synchronous active-high reset
//   fire_code[2:0]      fire code, sampled with fire
//   fire                one-cycle fire request
//   cmd_busy            high while a command byte is in flight
//   cmd_reject          one-cycle pulse when a request is dropped
//   start_tx            start strobe to uart_tx, held until tx_busy is seen
//   data_to_tx[7:0]     command byte to uart_tx
//   tx_busy             uart_tx busy
//   data_received[7:0]  byte from uart_rx
//   rx_done             uart_rx byte-ready (pulse or level)
//   parity_error        uart_rx parity flag
//   adc_value[11:0]     last good ADC reading
//   adc_valid           one-cycle pulse on adc_value update
//   frame_error         one-cycle pulse on a receive framing fault
module adc_link_master
  import adc_link_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = TimeoutClksDefault,
  parameter int unsigned CODE_MAX     = CodeMaxDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  fire_code,
  input  logic        fire,
  output logic        cmd_busy,
  output logic        cmd_reject,
  output logic        start_tx,
  output logic [7:0]  data_to_tx,
  input  logic        tx_busy,
  input  logic [7:0]  data_received,
  input  logic        rx_done,
  input  logic        parity_error,
  output logic [11:0] adc_value,
  output logic        adc_valid,
  output logic        frame_error
);

  tx_state_e  tx_state_q, tx_state_d;
  logic       start_q, start_d;
  logic [7:0] data_q, data_d;
  logic       reject_q, reject_d;
  logic       busy_q;
  logic       code_ok;

  assign code_ok = (32'(fire_code) <= CODE_MAX);

  always_comb begin
    tx_state_d = tx_state_q;
    start_d    = start_q;
    data_d     = data_q;
    reject_d   = 1'b0;

    case (tx_state_q)
      TIdle: begin
        if (fire) begin
          if (code_ok) begin
            data_d     = cmd_byte(fire_code);
            start_d    = 1'b1;
            tx_state_d = TReq;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      TReq: begin
        if (fire) reject_d = 1'b1;
        if (tx_busy) begin
          start_d    = 1'b0;
          tx_state_d = TBusy;
        end
      end
      TBusy: begin
        if (fire) reject_d = 1'b1;
        if (!tx_busy) tx_state_d = TIdle;
      end
      default: begin
        start_d    = 1'b0;
        tx_state_d = TIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TIdle;
      start_q    <= 1'b0;
      data_q     <= '0;
      reject_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      start_q    <= start_d;
      data_q     <= data_d;
      reject_q   <= reject_d;
      busy_q     <= (tx_state_d != TIdle);
    end
  end

  assign cmd_busy   = busy_q;
  assign cmd_reject = reject_q;
  assign start_tx   = start_q;
  assign data_to_tx = data_q;

  adc_frame_deframer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_deframer (
    .clk          (clk),
    .reset        (reset),
    .data_received(data_received),
    .rx_done      (rx_done),
    .parity_error (parity_error),
    .adc_value    (adc_value),
    .adc_valid    (adc_valid),
    .frame_error  (frame_error)
  );

endmodule

// File: tb/tb_adc_link_master.sv
// Bench for adc_link_master: TX handshake against a uart_tx model, RX frames
// from a vector table, and hand sequences for timeout, byte-wins and reset.
module tb_adc_link_master;

  localparam int unsigned Tmo = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  fire_code;
  logic        fire;
  logic        cmd_busy;
  logic        cmd_reject;
  logic        start_tx;
  logic [7:0]  data_to_tx;
  logic        tx_busy;
  logic [7:0]  data_received;
  logic        rx_done;
  logic        parity_error;
  logic [11:0] adc_value;
  logic        adc_valid;
  logic        frame_error;

  always #5 clk = ~clk;

  adc_link_master #(
    .TIMEOUT_CLKS(Tmo),
    .CODE_MAX    (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fire_code    (fire_code),
    .fire         (fire),
    .cmd_busy     (cmd_busy),
    .cmd_reject   (cmd_reject),
    .start_tx     (start_tx),
    .data_to_tx   (data_to_tx),
    .tx_busy      (tx_busy),
    .data_received(data_received),
    .rx_done      (rx_done),
    .parity_error (parity_error),
    .adc_value    (adc_value),
    .adc_valid    (adc_valid),
    .frame_error  (frame_error)
  );

  typedef struct packed {
    logic        ferr;
    logic        valid;
    logic [11:0] value;
  } exp_t;

  typedef struct {
    logic [7:0]  b;
    logic        par;
    logic        ferr;
    logic        valid;
    logic [11:0] value;  // adc_value expected after this byte
  } rx_vec_t;

  int      n_checks = 0;
  int      n_fail   = 0;
  int      tx_cnt   = 0;
  exp_t    sb_q[$];
  rx_vec_t rx_tab[16];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to the next falling edge, then run the uart_tx model and the RX monitor.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (reset) begin
      tx_cnt  = 0;
      tx_busy = 1'b0;
    end else begin
      if (tx_cnt == 0) begin
        if (start_tx) tx_cnt = 1;
      end else if (tx_cnt == 12) begin
        tx_cnt = 0;
      end else begin
        tx_cnt++;
      end
      tx_busy = (tx_cnt >= 3 && tx_cnt <= 12);
    end
    if (!reset && (adc_valid || frame_error)) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected: got valid=%0b ferr=%0b value=0x%0h, expected no output",
                 adc_valid, frame_error, adc_value);
      end else begin
        e = sb_q.pop_front();
        check("rx_ferr", 32'(frame_error), 32'(e.ferr));
        check("rx_valid", 32'(adc_valid), 32'(e.valid));
        if (e.valid) check("rx_value", 32'(adc_value), 32'(e.value));
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic par, input int hold);
    data_received = b;
    parity_error  = par;
    rx_done       = 1'b1;
    repeat (hold) tick();
    rx_done      = 1'b0;
    parity_error = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string name);
    int cyc = 0;
    while (cmd_busy && cyc < 40) begin
      tick();
      cyc++;
    end
    check(name, 32'(cmd_busy), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start_tx"}, 32'(start_tx), 0);
    check({tag, "_data_to_tx"}, 32'(data_to_tx), 0);
    check({tag, "_adc_value"}, 32'(adc_value), 0);
    check({tag, "_adc_valid"}, 32'(adc_valid), 0);
    check({tag, "_frame_error"}, 32'(frame_error), 0);
    check({tag, "_cmd_reject"}, 32'(cmd_reject), 0);
    check({tag, "_cmd_busy"}, 32'(cmd_busy), 0);
  endtask

  initial begin
    logic [7:0] last_byte;
    logic [7:0] exp_b;
    int         st_cnt;
    int         busy_cnt;
    int         bad_data;
    int         cyc;

    rx_tab[0]  = '{8'hAB, 1'b0, 1'b0, 1'b0, 12'h000};
    rx_tab[1]  = '{8'h15, 1'b0, 1'b0, 1'b1, 12'hAD5};
    rx_tab[2]  = '{8'hAB, 1'b0, 1'b0, 1'b0, 12'hAD5};
    rx_tab[3]  = '{8'h81, 1'b0, 1'b1, 1'b0, 12'hAD5};  // resync as new high
    rx_tab[4]  = '{8'h02, 1'b0, 1'b0, 1'b1, 12'h042};
    rx_tab[5]  = '{8'hAB, 1'b0, 1'b0, 1'b0, 12'h042};
    rx_tab[6]  = '{8'h15, 1'b1, 1'b1, 1'b0, 12'h042};  // parity error on low byte
    rx_tab[7]  = '{8'h15, 1'b0, 1'b1, 1'b0, 12'h042};  // low byte without high
    rx_tab[8]  = '{8'h40, 1'b0, 1'b1, 1'b0, 12'h042};
    rx_tab[9]  = '{8'hAB, 1'b0, 1'b0, 1'b0, 12'h042};
    rx_tab[10] = '{8'hC0, 1'b0, 1'b1, 1'b0, 12'h042};  // x1 tag in WAIT_LO
    rx_tab[11] = '{8'h3F, 1'b0, 1'b1, 1'b0, 12'h042};
    rx_tab[12] = '{8'hAB, 1'b1, 1'b1, 1'b0, 12'h042};  // parity error on high byte
    rx_tab[13] = '{8'h80, 1'b0, 1'b0, 1'b0, 12'h042};
    rx_tab[14] = '{8'h3F, 1'b0, 1'b0, 1'b1, 12'h03F};
    rx_tab[15] = '{8'h7F, 1'b0, 1'b1, 1'b0, 12'h03F};

    reset         = 1'b1;
    fire          = 1'b0;
    fire_code     = 3'd0;
    tx_busy       = 1'b0;
    data_received = 8'h00;
    rx_done       = 1'b0;
    parity_error  = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // TX: every code, legal ones through the full uart_tx handshake.
    last_byte = 8'h00;
    for (int i = 0; i < 8; i++) begin
      exp_b     = 8'h40 | 8'(i);
      fire_code = 3'(i);
      fire      = 1'b1;
      tick();
      fire = 1'b0;
      if (i <= 5) begin
        check("tx_start", 32'(start_tx), 1);
        check("tx_byte", 32'(data_to_tx), 32'(exp_b));
        check("tx_busy_rise", 32'(cmd_busy), 1);
        check("tx_no_reject", 32'(cmd_reject), 0);
        st_cnt   = 1;
        busy_cnt = 1;
        bad_data = 0;
        cyc      = 0;
        while (cmd_busy && cyc < 40) begin
          tick();
          cyc++;
          if (start_tx) st_cnt++;
          if (cmd_busy) busy_cnt++;
          if (data_to_tx !== exp_b) bad_data++;
        end
        check("tx_start_cycles", st_cnt, 3);
        check("tx_cmd_busy_cycles", busy_cnt, 13);
        check("tx_byte_stable", bad_data, 0);
        check("tx_back_idle", 32'(cmd_busy), 0);
        last_byte = exp_b;
      end else begin
        check("rej_pulse", 32'(cmd_reject), 1);
        check("rej_no_start", 32'(start_tx), 0);
        check("rej_not_busy", 32'(cmd_busy), 0);
        check("rej_byte_kept", 32'(data_to_tx), 32'(last_byte));
        tick();
        check("rej_pulse_end", 32'(cmd_reject), 0);
      end
    end

    // TX: fire while a command is in T_BUSY is dropped.
    fire_code = 3'd3;
    fire      = 1'b1;
    tick();
    fire = 1'b0;
    repeat (4) tick();
    check("busy_tx_busy", 32'(tx_busy), 1);
    fire_code = 3'd1;
    fire      = 1'b1;
    tick();
    fire = 1'b0;
    check("busy_reject", 32'(cmd_reject), 1);
    check("busy_byte_kept", 32'(data_to_tx), 32'h43);
    check("busy_no_start", 32'(start_tx), 0);
    tick();
    check("busy_reject_end", 32'(cmd_reject), 0);
    wait_idle("busy_idle");

    // RX: vector table, rx_done held as a 3-cycle level.
    for (int i = 0; i < 16; i++) begin
      if (rx_tab[i].ferr || rx_tab[i].valid)
        sb_q.push_back('{ferr: rx_tab[i].ferr, valid: rx_tab[i].valid, value: rx_tab[i].value});
      send_byte(rx_tab[i].b, rx_tab[i].par, 3);
      check("rx_hold_value", 32'(adc_value), 32'(rx_tab[i].value));
    end
    check("rx_table_drained", sb_q.size(), 0);

    // Timeout: high byte then silence.
    send_byte(8'hAB, 1'b0, 1);
    sb_q.push_back('{ferr: 1'b1, valid: 1'b0, value: 12'h000});
    cyc = 1;
    while (!frame_error && cyc < 3 * Tmo) begin
      tick();
      cyc++;
    end
    check("timeout_latency", cyc, Tmo);
    check("timeout_keeps_value", 32'(adc_value), 32'h03F);

    // A low byte landing exactly on the timeout cycle wins.
    data_received = 8'h9E;
    rx_done       = 1'b1;
    tick();
    rx_done = 1'b0;
    repeat (Tmo - 1) tick();
    sb_q.push_back('{ferr: 1'b0, valid: 1'b1, value: 12'h7A1});
    data_received = 8'h21;
    rx_done       = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
    check("byte_wins_value", 32'(adc_value), 32'h7A1);

    // Reset with RX in WAIT_LO and TX in T_REQ.
    send_byte(8'hAB, 1'b0, 1);
    fire_code = 3'd4;
    fire      = 1'b1;
    tick();
    fire = 1'b0;
    check("pre_reset_start", 32'(start_tx), 1);
    reset = 1'b1;
    tick();
    check_all_zero("mid_reset");
    reset = 1'b0;
    tick();
    sb_q.push_back('{ferr: 1'b1, valid: 1'b0, value: 12'h000});
    send_byte(8'h15, 1'b0, 1);
    check("post_reset_value", 32'(adc_value), 0);
    st_cnt = 0;
    repeat (20) begin
      tick();
      if (start_tx) st_cnt++;
    end
    check("post_reset_no_resend", st_cnt, 0);
    check("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_link_master.md
Name: adc_link_master

Overview:
- Main-board end of the UART link to a gate-driver/ADC board.
- Send path: turns a fire request (code 0..5) into one command byte on the byte-level UART transmitter.
- Receive path: rebuilds 12-bit ADC readings from two-byte frames arriving on the UART receiver and presents them on a 12-bit bus for the main-board pins.
- Sits between uart_tx/uart_rx (instantiated by the top) and main-board logic.

Parameters:
- TIMEOUT_CLKS, 48000: maximum clocks between high and low frame bytes (1 ms at 48 MHz).
- CODE_MAX, 5: highest legal fire code.

Ports:
- clk  in  1  system clock (48 MHz HFOSC)
- reset  in  1  synchronous, active-high reset
- fire_code  in  3  fire code, sampled on fire
- fire  in  1  one-cycle fire request strobe
- cmd_busy  out  1  high while a command is in flight
- cmd_reject  out  1  one-cycle pulse: request dropped (busy or code > CODE_MAX)
- start_tx  out  1  to uart_tx start_tx
- data_to_tx  out  8  to uart_tx data_to_tx
- tx_busy  in  1  from uart_tx
- data_received  in  8  from uart_rx
- rx_done  in  1  from uart_rx (pulse or level; edge-detected)
- parity_error  in  1  from uart_rx, qualified by rx_done edge
- adc_value  out  12  last good ADC reading
- adc_valid  out  1  one-cycle pulse on adc_value update
- frame_error  out  1  one-cycle pulse on any receive framing fault

Behaviour:
Reset (synchronous, active-high, overrides everything):
- All outputs drive 0: start_tx, data_to_tx, adc_value, adc_valid, frame_error, cmd_reject, cmd_busy.
- TX FSM goes to T_IDLE; RX FSM goes to R_WAIT_HI.
- rx_done edge-detect register clears; timer clears.
- A frame or command in progress is abandoned. No byte is re-sent after reset.

Command byte: {2'b01, 3'b000, code[2:0]}.

TX FSM (T_IDLE, T_REQ, T_BUSY):
- T_IDLE, fire=1, code<=CODE_MAX: data_to_tx <= command byte, start_tx <= 1, go T_REQ.
- T_IDLE, fire=1, code>CODE_MAX: cmd_reject pulses next cycle, stay in T_IDLE.
- T_REQ: hold start_tx=1 until tx_busy=1 is sampled, then start_tx <= 0, go T_BUSY.
- T_BUSY: when tx_busy=0, go T_IDLE.
- cmd_busy = (state != T_IDLE), registered with the state.
- fire while not in T_IDLE: cmd_reject pulses, request dropped, data_to_tx unchanged.
- data_to_tx stays stable from T_REQ entry until T_IDLE.

rx_done edge detect:
- A byte event is a cycle where rx_done=1 and the previous sample was 0.
- Exactly one event per received byte, whether rx_done is a pulse or a level.

Frame format:
- High byte: {1'b1, 1'b0, adc[11:6]}.
- Low byte: {1'b0, 1'b0, adc[5:0]}.

RX FSM (R_WAIT_HI, R_WAIT_LO), evaluated on byte events:
- Parity error (any state): byte discarded, frame_error pulse, go R_WAIT_HI.
- R_WAIT_HI, byte[7:6]=10: latch byte[5:0] as hi, clear timer, go R_WAIT_LO.
- R_WAIT_HI, other byte: frame_error pulse, stay.
- R_WAIT_LO, byte[7:6]=00: adc_value <= {hi, byte[5:0]}, adc_valid pulse, go R_WAIT_HI.
- R_WAIT_LO, byte[7:6]=10: frame_error pulse; byte is taken as a new hi (resync), timer restarts, stay.
- R_WAIT_LO, byte[7:6]=x1: frame_error pulse, go R_WAIT_HI.
- R_WAIT_LO, no event: timer increments. At TIMEOUT_CLKS-1, frame_error pulse and go R_WAIT_HI. If a byte event lands on the timeout cycle, the byte wins.

Timing and widths:
- Latency: event in cycle N gives adc_value/adc_valid/frame_error visible in cycle N+1.
- Timer width is $clog2(TIMEOUT_CLKS).
- adc_value holds its value between updates. No arithmetic on data, concatenation only.
- TX and RX paths are fully independent and may be active in the same cycle.

Decomposition:
- Shared package/header, next to UART.vh: command marker 2'b01, frame tags HI=2'b10 / LO=2'b00, state encodings, CODE_MAX default.
- Natural sub-module: adc_frame_deframer (edge detect, RX FSM, timer).
- TX FSM stays in the parent.

Test Plan:
- fire=1 with code=3; uart_tx model raises tx_busy 2 cycles after start_tx and holds it 10 cycles → data_to_tx=8'h43; start_tx drops the cycle after tx_busy is seen; cmd_busy falls after tx_busy falls.
- code=6 in idle, then fire during T_BUSY → two cmd_reject pulses, no start_tx, data_to_tx unchanged.
- Bytes 8'hAB then 8'h15 (rx_done held high 3 cycles each) → adc_value=12'hAD5, one adc_valid pulse per frame.
- 8'hAB then no byte for TIMEOUT_CLKS → frame_error pulse, adc_value keeps its old value; then 8'h80, 8'h3F → adc_value=12'h03F.
- 8'hAB, 8'h81, 8'h02 → one frame_error, then adc_value=12'h042; separately, a low byte with parity_error=1 → frame_error and no adc_valid.
- reset asserted in R_WAIT_LO and T_REQ → next cycle all outputs are 0; a following low byte alone gives frame_error only.
